mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port word memory (1024 × 32, combinational read, write on rising `clk`) between the instruction-fetch port and the data port of the MIPS core. Each cycle it selects at most one requester and drives the memory port combinationally. It registers the read data and returns a one-cycle acknowledge. A data-port lock gives atomic read-modify-write sequences, with a bounded lock duration.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port word memory between the fetch and
//                data ports. Round-robin ties, one-cycle registered acks, and
//                a bounded data-port lock. Define ARB_FIXED_PRIO_EN to make
//                the data port always win ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_lock,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int c_CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FORCE    = 2'd2
    } lock_state_t;

    lock_state_t        r_state;
    lock_state_t        w_state_nxt;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic [c_CNT_W-1:0] w_lock_cnt_nxt;

    logic        r_i_ack;
    logic        r_d_ack;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic w_i_elig;
    logic w_d_elig;
    logic w_d_wins_tie;
    logic w_grant_i;
    logic w_grant_d;

    // A port is ignored while its own ack is high; the lock states gate each side.
    assign w_i_elig = i_req && !r_i_ack && (r_state != ST_LOCKED);
    assign w_d_elig = d_req && !r_d_ack && (r_state != ST_FORCE);

`ifdef ARB_FIXED_PRIO_EN
    assign w_d_wins_tie = 1'b1;
`else
    logic r_last;

    assign w_d_wins_tie = !r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant_i) begin
            r_last <= 1'b0;
        end else if (w_grant_d) begin
            r_last <= 1'b1;
        end
    end
`endif

    assign w_grant_d = w_d_elig && (!w_i_elig || w_d_wins_tie);
    assign w_grant_i = w_i_elig && !w_grant_d;

    // Write enable is gated by reset so an asserted reset aborts an in-flight write.
    always_comb begin
        mem_write = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (w_grant_i) begin
            mem_addr = i_addr;
        end else if (w_grant_d) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_write = rst_n;
                mem_wdata = d_wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_grant_d && d_lock) begin
                    w_state_nxt    = ST_LOCKED;
                    w_lock_cnt_nxt = '0;
                end
            end
            ST_LOCKED: begin
                if (!d_lock) begin
                    w_state_nxt = ST_UNLOCKED;
                end else if (r_lock_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_FORCE;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                end
            end
            ST_FORCE: begin
                if (w_grant_i || !i_req) begin
                    w_state_nxt = ST_UNLOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_UNLOCKED;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else begin
            r_i_ack <= w_grant_i;
            r_d_ack <= w_grant_d;
            if (w_grant_i) begin
                r_i_rdata <= mem_rdata;
            end
            if (w_grant_d) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter with a
//                1024 x 32 behavioural memory (LOCK_MAX = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_lock;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_val;
    logic [31:0] mem_before;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .LOCK_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_lock    (d_lock),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_write) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic       fetch_first;
    logic [7:0] exp_i_seq;
    logic [7:0] exp_d_seq;

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        fetch_first = 1'b0;
`else
        fetch_first = 1'b1;
`endif
        rst_n = 1'b0; i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_lock = 1'b0;
        pre_we = 1'b1; pre_idx = 10'd5; pre_val = 32'hDEADBEEF;
        step();
        pre_we = 1'b0;

        // Reset: a write request must not reach the memory, outputs are zero.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1;
        #1;
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        step();
        chk("rst_i_ack",   {31'd0, i_ack}, 32'd0);
        chk("rst_d_ack",   {31'd0, d_ack}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // Single fetch.
        i_req = 1'b1; i_addr = 32'h14;
        #1;
        chk("fetch_mem_addr",  mem_addr, 32'h14);
        chk("fetch_mem_write", {31'd0, mem_write}, 32'd0);
        step();
        chk("fetch_i_ack",   {31'd0, i_ack}, 32'd1);
        chk("fetch_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("fetch_d_ack",   {31'd0, d_ack}, 32'd0);
        i_req = 1'b0;
        step();
        chk("fetch_ack_pulse", {31'd0, i_ack}, 32'd0);

        // Write then read back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        #1;
        chk("wr_mem_write", {31'd0, mem_write}, 32'd1);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        chk("wr_mem_addr",  mem_addr, 32'h40);
        step();
        chk("wr_d_ack", {31'd0, d_ack}, 32'd1);
        chk("wr_mem_content", mem[16], 32'h12345678);
        d_we = 1'b0;
        #1;
        chk("ack_cycle_ignored", {31'd0, mem_write}, 32'd0);
        chk("ack_cycle_addr",    mem_addr, 32'd0);
        step();
        chk("rd_gap_d_ack", {31'd0, d_ack}, 32'd0);
        step();
        chk("rd_d_ack",     {31'd0, d_ack}, 32'd1);
        chk("rd_d_rdata",   d_rdata, 32'h12345678);
        chk("rd_i_rdata_hold", i_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        step();

        // Contention from reset release.
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("cont_i_ack_%0d", k), {31'd0, i_ack},
                {31'd0, ((k % 2) == 0) == fetch_first});
            chk($sformatf("cont_d_ack_%0d", k), {31'd0, d_ack},
                {31'd0, ((k % 2) == 0) != fetch_first});
        end
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Lock held for three cycles, then released.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_lock = 1'b1;
        step();
        chk("lock_d_ack0",  {31'd0, d_ack}, 32'd1);
        chk("lock_d_rdata", d_rdata, 32'h12345678);
        i_req = 1'b1; i_addr = 32'h14;
        chk("lock_i_ack_l1", {31'd0, i_ack}, 32'd0);
        step();
        chk("lock_i_ack_l2", {31'd0, i_ack}, 32'd0);
        #1;
        chk("lock_data_owns", mem_addr, 32'h40);
        step();
        chk("lock_d_ack1",   {31'd0, d_ack}, 32'd1);
        chk("lock_i_ack_l3", {31'd0, i_ack}, 32'd0);
        d_lock = 1'b0; d_req = 1'b0;
        step();
        chk("lock_i_ack_l4", {31'd0, i_ack}, 32'd0);
        #1;
        chk("unlock_fetch_addr", mem_addr, 32'h14);
        step();
        chk("unlock_i_ack",   {31'd0, i_ack}, 32'd1);
        chk("unlock_i_rdata", i_rdata, 32'hDEADBEEF);
        i_req = 1'b0;
        step();

        // Lock timeout with LOCK_MAX = 4.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_lock = 1'b1;
        exp_i_seq = 8'b0100_0000;
        exp_d_seq = 8'b1010_1010;
        for (int t = 1; t < 8; t++) begin
            step();
            if (t == 1) i_req = 1'b1;
            chk($sformatf("tmo_i_ack_%0d", t), {31'd0, i_ack}, {31'd0, exp_i_seq[t]});
            chk($sformatf("tmo_d_ack_%0d", t), {31'd0, d_ack}, {31'd0, exp_d_seq[t]});
        end
        d_lock = 1'b0; d_req = 1'b0; i_req = 1'b0;
        step();
        step();

        // Asynchronous reset in the middle of a write grant.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
        mem_before = mem[32];
        #1;
        chk("arst_pre_write", {31'd0, mem_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("arst_i_ack",     {31'd0, i_ack}, 32'd0);
        chk("arst_d_ack",     {31'd0, d_ack}, 32'd0);
        chk("arst_i_rdata",   i_rdata, 32'd0);
        chk("arst_d_rdata",   d_rdata, 32'd0);
        step();
        chk("arst_mem_unchanged", mem[32], mem_before);
        chk("arst_no_ack", {31'd0, d_ack}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
